// File: rtl/out_intf_mc_aggregator.sv
// ----------------------------------------------------------------------------
// out_intf_mc_aggregator
//
// Merges NUM_CH independent valid/ready output streams onto one tagged
// output stream for the out_intf monitor/transactor. Each channel has its own
// FIFO. A round-robin arbiter selects which non-empty FIFO feeds the single
// output register. With drop_mode set, a channel never backpressures: a beat
// that arrives while its FIFO is full is discarded and counted in a
// saturating per-channel drop counter.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   ch_valid    per-channel beat valid
//   ch_ready    per-channel accept (always 1 in drop mode)
//   ch_data     per-channel data, channel i at [i*DATA_W +: DATA_W]
//   drop_mode   0 = backpressure when full, 1 = drop when full
//   out_valid   merged beat valid (registered)
//   out_ready   downstream accept
//   out_data    merged beat data (registered)
//   out_ch      source channel of out_data (registered)
//   drop_cnt    per-channel dropped-beat count, channel i at [i*CNT_W +: CNT_W]
//   fifo_empty  per-channel FIFO empty flag
// ----------------------------------------------------------------------------
module out_intf_mc_aggregator #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic                       drop_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic [NUM_CH*CNT_W-1:0]    drop_cnt,
  output logic [NUM_CH-1:0]          fifo_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  // Pointers differing only in the wrap bit mean the FIFO is full.
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // Storage and state
  logic [DATA_W-1:0] mem_q      [NUM_CH][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d      [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q   [NUM_CH];
  logic [PW-1:0]     wr_ptr_d   [NUM_CH];
  logic [PW-1:0]     rd_ptr_q   [NUM_CH];
  logic [PW-1:0]     rd_ptr_d   [NUM_CH];
  logic [CNT_W-1:0]  drop_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  drop_cnt_d [NUM_CH];

  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [CH_W-1:0]   out_ch_q;
  logic [CH_W-1:0]   out_ch_d;
  // Last granted channel; the search starts just after it.
  logic [CH_W-1:0]   last_q;
  logic [CH_W-1:0]   last_d;

  // Combinational status / control
  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] drop_s;
  logic [NUM_CH-1:0] pop_s;
  logic [NUM_CH-1:0] ready_s;
  logic [CH_W-1:0]   grant_s;
  logic [CH_W-1:0]   cand_s;
  logic              grant_vld_s;
  logic              load_s;
  int                idx_s;

  // Per-channel FIFO status and input-side handshake decisions.
  // Full is taken from the registered pointers, i.e. before any pop this cycle.
  always_comb begin
    full_s  = '0;
    empty_s = '0;
    push_s  = '0;
    drop_s  = '0;
    ready_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      empty_s[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_s[i]  = ((wr_ptr_q[i] ^ rd_ptr_q[i]) == FULL_XOR);
      if (drop_mode) begin
        ready_s[i] = 1'b1;
      end else begin
        ready_s[i] = !full_s[i];
      end
      push_s[i] = ch_valid[i] && !full_s[i];
      drop_s[i] = ch_valid[i] && full_s[i] && drop_mode;
    end
  end

  // Round-robin search over non-empty FIFOs, starting after last_q.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    idx_s       = 0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_s = int'(last_q) + k;
      if (idx_s >= NUM_CH) begin
        idx_s = idx_s - NUM_CH;
      end else begin
        idx_s = idx_s;
      end
      cand_s = CH_W'(idx_s);
      if (!grant_vld_s && !empty_s[cand_s]) begin
        grant_s     = cand_s;
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = grant_s;
      end
    end
  end

  // Output register load/hold/drain and the matching FIFO pop.
  always_comb begin
    load_s      = (!out_valid_q || out_ready) && grant_vld_s;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    pop_s       = '0;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[grant_s][rd_ptr_q[grant_s][AW-1:0]];
      out_ch_d    = grant_s;
      last_d      = grant_s;
      for (int i = 0; i < NUM_CH; i++) begin
        pop_s[i] = (grant_s == CH_W'(i));
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FIFO pointer, storage and drop-counter next state.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] = ch_data[i*DATA_W +: DATA_W];
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      if (drop_s[i] && (drop_cnt_q[i] != CNT_MAX)) begin
        drop_cnt_d[i] = drop_cnt_q[i] + CNT_W'(1);
      end else begin
        drop_cnt_d[i] = drop_cnt_q[i];
      end
    end
  end

  // State registers; reset discards every buffered and in-flight beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        drop_cnt_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= LAST_CH;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  // Flatten the per-channel counters onto the output bus.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_cnt[i*CNT_W +: CNT_W] = drop_cnt_q[i];
    end
  end

  assign ch_ready   = ready_s;
  assign fifo_empty = empty_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;

endmodule

// File: doc/out_intf_mc_aggregator.md
Name: out_intf_mc_aggregator

Overview:
- Parametrised multi-channel successor to the single-channel output interface path.
- Accepts NUM_CH independent valid/ready output streams, buffers each in a per-channel FIFO, and merges them round-robin onto one tagged output stream for the out_intf monitor/transactor.
- Adds a selectable drop mode with per-channel saturating drop counters; the single-channel path has neither.
- Synthesizable for emulation; sits between DUT output ports and the HDL-side interface BFM.

Parameters:
- NUM_CH, 4, number of input channels (1..16)
- DATA_W, 32, data width per beat
- FIFO_DEPTH, 8, entries per channel FIFO (power of 2, >=2)
- CNT_W, 16, width of each drop counter

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ch_valid  input  NUM_CH  per-channel beat valid
- ch_ready  output  NUM_CH  per-channel accept
- ch_data  input  NUM_CH*DATA_W  per-channel data; channel i in bits [i*DATA_W +: DATA_W]
- drop_mode  input  1  0 = backpressure, 1 = drop when full
- out_valid  output  1  merged beat valid
- out_ready  input  1  downstream accept
- out_data  output  DATA_W  merged beat data
- out_ch  output  max(1,$clog2(NUM_CH))  source channel of out_data
- drop_cnt  output  NUM_CH*CNT_W  per-channel dropped-beat count, saturating
- fifo_empty  output  NUM_CH  per-channel FIFO empty flag

Behaviour:
- Reset (asynchronous assert, synchronous-release usage):
  - all FIFOs empty; fifo_empty all 1s; out_valid=0; out_data=0; out_ch=0; drop_cnt all 0.
  - arbiter pointer set so channel 0 has highest priority on the first grant.
  - reset mid-transfer discards all buffered and in-flight beats; no partial state survives.
- Input handshake: a beat is written when ch_valid[i] && ch_ready[i] at a clock edge.
  - backpressure mode: ch_ready[i] = !full[i].
  - drop mode: ch_ready[i] = 1. If full[i] and ch_valid[i], the beat is discarded and drop_cnt[i] increments.
  - full is evaluated before any same-cycle pop, so a beat arriving on a full FIFO is dropped even if that FIFO pops in the same cycle.
  - drop_cnt saturates at 2^CNT_W-1 and clears only on reset.
- drop_mode is sampled combinationally each cycle; changing it affects ch_ready and the drop decision from the same cycle.
- FIFO: FIFO_DEPTH entries; pointers carry an extra wrap bit; full when the pointers differ only in the wrap bit.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the level unchanged.
- Output stage: one output register (out_valid/out_data/out_ch).
  - Loads when (!out_valid || out_ready) and at least one FIFO is non-empty; the loaded beat is popped from its FIFO in that cycle.
  - While out_valid && !out_ready, out_data and out_ch hold stable and no pop occurs.
  - out_valid deasserts after a transfer only if no FIFO is non-empty.
- Latency: a beat written at edge N can appear on out_valid after edge N+1 at the earliest. Back-to-back throughput is 1 beat/cycle with out_ready held high.
- Arbitration: round-robin over non-empty FIFOs, starting at the channel after the last granted one. The pointer advances only on a grant. Empty channels are skipped with no bubble.
- Ordering: per-channel beat order is preserved. No ordering is guaranteed across channels.
- NUM_CH=1: the arbiter degenerates and out_ch is tied 0.

Test Plan:
- Reset, then push 0xA0,0xA1 on ch0 with out_ready=1 -> out_data 0xA0 then 0xA1, out_ch=0; first out_valid one cycle after the first write; fifo_empty[0]=1 afterwards.
- All 4 channels hold one beat each (0x10,0x20,0x30,0x40), out_ready=1 -> output order ch0,ch1,ch2,ch3 on consecutive cycles; then ch3 alone then ch1 -> grants ch3, ch1.
- Backpressure: out_ready=0, drive ch2 continuously -> 1 beat in output register, 8 in FIFO, then ch_ready[2]=0; release out_ready -> 9 beats out in order, none lost, drop_cnt[2]=0.
- Drop mode: out_ready=0, push 12 beats on ch1 -> ch_ready[1] stays 1, drop_cnt[1]=3, and the first 9 beats are delivered once out_ready=1.
- Saturation with CNT_W=4: 20 drops on ch0 -> drop_cnt[0]=15, held at 15.
- Assert reset mid-burst with out_valid=1 and FIFOs partly full -> out_valid=0, fifo_empty all 1s, drop_cnt=0 immediately; the next post-reset grant goes to ch0.
